// File: rtl/l2_pkg.sv
// Shared types for the set-associative L2: FSM states, default geometry
// widths and the per-way metadata layout.
package l2_pkg;

  localparam int ADDR_W_D = 28;
  localparam int LINE_W_D = 128;
  localparam int SETS_D   = 16;
  localparam int WAYS_D   = 4;
  localparam int CNT_W_D  = 16;

  // Age/way-index width; a direct-mapped cache still needs one bit.
  function automatic int age_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  localparam int IDX_W = $clog2(SETS_D);
  localparam int TAG_W = ADDR_W_D - IDX_W;
  localparam int AGE_W = age_w(WAYS_D);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITEBACK,
    S_ALLOCATE
  } state_e;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
    logic [AGE_W-1:0] age;
  } meta_t;

endpackage

// File: rtl/l2_lru_ctrl.sv
// True-LRU helper for one set: picks the victim way and produces the
// age vector after touching a way (age 0 = MRU, WAYS-1 = LRU).
// Ports: age_i/valid_i set state, touch_i way made MRU,
//        victim_o replacement way, age_o updated ages.
module l2_lru_ctrl
  import l2_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int AW   = 2
) (
  input  logic [WAYS*AW-1:0] age_i,
  input  logic [WAYS-1:0]    valid_i,
  input  logic [AW-1:0]      touch_i,
  output logic [AW-1:0]      victim_o,
  output logic [WAYS*AW-1:0] age_o
);

  logic          found;
  logic [AW-1:0] old_age;
  logic [AW-1:0] a;

  always_comb begin
    victim_o = '0;
    found    = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!valid_i[w] && !found) begin
        victim_o = AW'(w);
        found    = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_i[w*AW +: AW] == AW'(WAYS-1))
          victim_o = AW'(w);
      end
    end
  end

  always_comb begin
    age_o   = age_i;
    old_age = age_i[touch_i*AW +: AW];
    a       = '0;
    for (int w = 0; w < WAYS; w++) begin
      a = age_i[w*AW +: AW];
      if (AW'(w) == touch_i)
        age_o[w*AW +: AW] = '0;
      else if (a < old_age)
        age_o[w*AW +: AW] = a + 1'b1;
    end
  end

endmodule

// File: rtl/l2_cache_assoc.sv
// N-way set-associative write-back/write-allocate L2 with true LRU.
// Ports: L1 side read/write/addr/wdata -> rdata/ready; memory side
// mem_read/mem_write/mem_addr/mem_wdata <- mem_rdata/mem_ready;
// hit_count/miss_count saturating performance counters.
module l2_cache_assoc
  import l2_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int LINE_W = LINE_W_D,
  parameter int SETS   = SETS_D,
  parameter int WAYS   = WAYS_D,
  parameter int CNT_W  = CNT_W_D
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata,
  output logic              ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int IW = $clog2(SETS);
  localparam int TW = ADDR_W - IW;
  localparam int AW = age_w(WAYS);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              req_wr_q, req_wr_d;
  logic [LINE_W-1:0] req_wdata_q, req_wdata_d;
  logic [AW-1:0]     victim_q, victim_d;

  logic              ready_q, ready_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]  hit_q, hit_d;
  logic [CNT_W-1:0]  miss_q, miss_d;

  logic [SETS-1:0][WAYS-1:0] valid_q, dirty_q;
  logic [TW-1:0]             tag_q  [SETS][WAYS];
  logic [LINE_W-1:0]         line_q [SETS][WAYS];
  logic [WAYS*AW-1:0]        age_q  [SETS];

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  assign idx = req_addr_q[IW-1:0];
  assign tag = req_addr_q[ADDR_W-1:IW];

  logic          hit;
  logic [AW-1:0] hit_way;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = AW'(w);
      end
    end
  end

  logic [AW-1:0]      victim;
  logic [WAYS*AW-1:0] age_upd;

  l2_lru_ctrl #(
    .WAYS(WAYS),
    .AW  (AW)
  ) u_lru (
    .age_i   (age_q[idx]),
    .valid_i (valid_q[idx]),
    .touch_i (hit_way),
    .victim_o(victim),
    .age_o   (age_upd)
  );

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] c
  );
    return (&c) ? c : c + 1'b1;
  endfunction

  logic              line_we;
  logic [AW-1:0]     line_way;
  logic [LINE_W-1:0] line_wd;
  logic              fill_we;
  logic              dirty_set;
  logic              dirty_clr;
  logic              age_we;

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_wr_d    = req_wr_q;
    req_wdata_d = req_wdata_q;
    victim_d    = victim_q;
    ready_d     = 1'b0;
    rdata_d     = rdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    line_we     = 1'b0;
    line_way    = hit_way;
    line_wd     = req_wdata_q;
    fill_we     = 1'b0;
    dirty_set   = 1'b0;
    dirty_clr   = 1'b0;
    age_we      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (read || write) begin
          state_d     = S_COMPARE;
          req_addr_d  = addr;
          req_wr_d    = !read;
          req_wdata_d = wdata;
        end
      end
      S_COMPARE: begin
        if (hit) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          hit_d   = sat_inc(hit_q);
          age_we  = 1'b1;
          if (req_wr_q) begin
            line_we   = 1'b1;
            dirty_set = 1'b1;
          end else begin
            rdata_d = line_q[idx][hit_way];
          end
        end else begin
          miss_d   = sat_inc(miss_q);
          victim_d = victim;
          if (dirty_q[idx][victim]) begin
            state_d     = S_WRITEBACK;
            mem_write_d = 1'b1;
            mem_addr_d  = {tag_q[idx][victim], idx};
            mem_wdata_d = line_q[idx][victim];
          end else begin
            state_d    = S_ALLOCATE;
            mem_read_d = 1'b1;
            mem_addr_d = req_addr_q;
          end
        end
      end
      S_WRITEBACK: begin
        if (mem_ready) begin
          state_d     = S_ALLOCATE;
          mem_write_d = 1'b0;
          dirty_clr   = 1'b1;
          mem_read_d  = 1'b1;
          mem_addr_d  = req_addr_q;
        end
      end
      S_ALLOCATE: begin
        if (mem_ready) begin
          state_d    = S_COMPARE;
          mem_read_d = 1'b0;
          fill_we    = 1'b1;
          line_we    = 1'b1;
          line_way   = victim_q;
          line_wd    = mem_rdata;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      req_addr_q  <= '0;
      req_wr_q    <= 1'b0;
      req_wdata_q <= '0;
      victim_q    <= '0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_wr_q    <= req_wr_d;
      req_wdata_q <= req_wdata_d;
      victim_q    <= victim_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w*AW +: AW] <= AW'(w);
    end else begin
      if (age_we)
        age_q[idx] <= age_upd;
      if (dirty_set)
        dirty_q[idx][hit_way] <= 1'b1;
      if (dirty_clr)
        dirty_q[idx][victim_q] <= 1'b0;
      if (fill_we) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
    end
  end

  // Line and tag storage are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (line_we)
      line_q[idx][line_way] <= line_wd;
    if (fill_we)
      tag_q[idx][victim_q] <= tag;
  end

  assign ready      = ready_q;
  assign rdata      = rdata_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule
